bht_ctrl: RTL

Branch-history-table port controller for the fetch stage. It owns the single read/write port of a `ram_sp` instance holding 2-bit saturating branch counters. It serves zero-latency prediction lookups from fetch and buffers retire-time counter updates in a small coalescing queue. Queued updates drain into the RAM on cycles when fetch does not need the port.

---
 rtl/bht_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bht_ctrl.sv
// Branch-history-table port controller: zero-latency lookups plus a coalescing update queue.
// Define BHT_FWD_EN to forward queued counters to lookups before they drain.
module bht_ctrl #(
    parameter int unsigned LOGINDEX = 8,
    parameter int unsigned CTRW     = 2,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned LOGQ     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lk_valid,
    input  logic [LOGINDEX-1:0] lk_index,
    output logic                lk_ready,
    output logic                lk_taken,
    output logic [CTRW-1:0]     lk_ctr,
    input  logic                up_valid,
    input  logic [LOGINDEX-1:0] up_index,
    input  logic [CTRW-1:0]     up_ctr,
    input  logic                up_taken,
    output logic                up_ready,
    output logic                ram_we,
    output logic [LOGINDEX-1:0] ram_index,
    output logic [CTRW-1:0]     ram_data,
    input  logic [CTRW-1:0]     ram_rdata,
    output logic [LOGQ:0]       q_count
);

    localparam logic [CTRW-1:0] CtrMax = {CTRW{1'b1}};
    localparam logic [LOGQ:0]   QFull  = (LOGQ + 1)'(QDEPTH);

    logic [LOGINDEX-1:0] idx_q [QDEPTH];
    logic [LOGINDEX-1:0] idx_d [QDEPTH];
    logic [CTRW-1:0]     ctr_q [QDEPTH];
    logic [CTRW-1:0]     ctr_d [QDEPTH];
    logic [QDEPTH-1:0]   vld_q, vld_d;
    logic [LOGQ-1:0]     head_q, head_d;
    logic [LOGQ-1:0]     tail_q, tail_d;
    logic [LOGQ:0]       cnt_q, cnt_d;

    logic                q_full;
    logic                lk_grant;
    logic                drain;
    logic                enq;
    logic                up_hit;
    logic [LOGQ-1:0]     up_pos;
    logic [CTRW-1:0]     up_base;
    logic [CTRW-1:0]     up_next;
    logic                alloc;
    logic                merge;

    // Port arbitration: lookups win unless the queue is full.
    assign q_full   = (cnt_q == QFull);
    assign lk_grant = lk_valid && !q_full;
    assign drain    = !lk_grant && (cnt_q != '0);
    assign enq      = up_valid && !q_full;

    assign lk_ready  = !q_full;
    assign up_ready  = !q_full;
    assign q_count   = cnt_q;
    assign ram_we    = drain;
    assign ram_index = drain ? idx_q[head_q] : lk_index;
    assign ram_data  = ctr_q[head_q];

    // Walk oldest to youngest so the last match is the youngest.
    always_comb begin
        up_hit = 1'b0;
        up_pos = '0;
        for (int unsigned k = 0; k < QDEPTH; k++) begin
            logic [LOGQ-1:0] p;
            p = head_q + LOGQ'(k);
            if (vld_q[p] && (idx_q[p] == up_index)) begin
                up_hit = 1'b1;
                up_pos = p;
            end
        end
    end

    always_comb begin
        up_base = up_hit ? ctr_q[up_pos] : up_ctr;
        if (up_taken) begin
            up_next = (up_base == CtrMax) ? up_base : up_base + CTRW'(1);
        end else begin
            up_next = (up_base == '0) ? up_base : up_base - CTRW'(1);
        end
    end

    // A hit on a head that leaves this cycle cannot be merged into; append instead.
    assign alloc = enq && (!up_hit || ((up_pos == head_q) && drain));
    assign merge = enq && !alloc;

    always_comb begin
        idx_d  = idx_q;
        ctr_d  = ctr_q;
        vld_d  = vld_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (drain) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + LOGQ'(1);
        end
        if (merge) begin
            ctr_d[up_pos] = up_next;
        end
        if (alloc) begin
            idx_d[tail_q] = up_index;
            ctr_d[tail_q] = up_next;
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + LOGQ'(1);
        end
        case ({alloc, drain})
            2'b10:   cnt_d = cnt_q + (LOGQ + 1)'(1);
            2'b01:   cnt_d = cnt_q - (LOGQ + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                idx_q[i] <= '0;
                ctr_q[i] <= '0;
            end
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            ctr_q  <= ctr_d;
            vld_q  <= vld_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef BHT_FWD_EN
    logic            fwd_hit;
    logic [CTRW-1:0] fwd_ctr;

    always_comb begin
        fwd_hit = 1'b0;
        fwd_ctr = '0;
        for (int unsigned k = 0; k < QDEPTH; k++) begin
            logic [LOGQ-1:0] p;
            p = head_q + LOGQ'(k);
            if (vld_q[p] && (idx_q[p] == lk_index)) begin
                fwd_hit = 1'b1;
                fwd_ctr = ctr_q[p];
            end
        end
    end

    assign lk_ctr = fwd_hit ? fwd_ctr : ram_rdata;
`else
    assign lk_ctr = ram_rdata;
`endif

    assign lk_taken = lk_ctr[CTRW-1];

endmodule
